// File: rtl/latch16_feed.sv
// Feeds a 16-bit transparent latch: accepts a word over valid/ready, opens the latch
// enable for OPEN_CYC cycles, then holds data for HOLD_CYC cycles after it closes.
//
// state   | meaning
// INIT    | idle, first cycle after reset release; not yet ready
// IDLE    | waiting for a word or a clear request
// OPEN    | lat_c high, latch transparent, lat_d frozen
// HOLD    | lat_c low, lat_d still frozen for hold time
module latch16_feed #(
  parameter int OPEN_CYC = 2,
  parameter int HOLD_CYC = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [0:15]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [0:15]      lat_d,
  output logic             lat_c,
  output logic             busy,
  output logic [0:15]      shadow,
  output logic [CNT_W-1:0] wcnt
);

  if (OPEN_CYC < 1 || OPEN_CYC > 15) begin : g_bad_open
    $error("latch16_feed: OPEN_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("latch16_feed: HOLD_CYC must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("latch16_feed: CNT_W must be at least 1");
  end

  localparam logic [3:0] OPEN_T = 4'(OPEN_CYC - 1);
  localparam logic [3:0] HOLD_T = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_OPEN = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [3:0]       tmr_q, tmr_nxt;
  logic [0:15]      lat_d_q, lat_d_nxt;
  logic             lat_c_q;
  logic [0:15]      shadow_q;
  logic [CNT_W-1:0] wcnt_q;
  logic             done;

  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    lat_d_nxt = lat_d_q;
    done      = 1'b0;
    case (state_q)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (clr) begin
          lat_d_nxt = '0;
          tmr_nxt   = OPEN_T;
          state_nxt = ST_OPEN;
        end else if (in_valid) begin
          lat_d_nxt = in_data;
          tmr_nxt   = OPEN_T;
          state_nxt = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (tmr_q == 4'd0) begin
          tmr_nxt   = HOLD_T;
          state_nxt = ST_HOLD;
        end else begin
          tmr_nxt = tmr_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (tmr_q == 4'd0) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr_q - 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // lat_c gets its own flop so the latch enable is glitch-free, not a state decode
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      tmr_q    <= '0;
      lat_d_q  <= '0;
      lat_c_q  <= 1'b0;
      shadow_q <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
      lat_d_q <= lat_d_nxt;
      lat_c_q <= (state_nxt == ST_OPEN);
      if (done) begin
        shadow_q <= lat_d_q;
        wcnt_q   <= wcnt_q + 1'b1;
      end
    end
  end

  assign in_ready = (state_q == ST_IDLE) && !clr;
  assign busy     = (state_q == ST_OPEN) || (state_q == ST_HOLD);
  assign lat_d    = lat_d_q;
  assign lat_c    = lat_c_q;
  assign shadow   = shadow_q;
  assign wcnt     = wcnt_q;

endmodule
